// File: rtl/riscboy_ppu_palette_lookup.sv
// Palette lookup stage: resolves paletted or direct pixels to RGB555 plus alpha,
// with a one-stage lookup pipeline and a 2-entry output FIFO toward the blender.
module riscboy_ppu_palette_lookup #(
    parameter int W_PIX     = 16,
    parameter int W_PAL_IDX = 8,
    parameter int W_COLOUR  = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [W_PIX-1:0]     in_data,
    input  logic                 in_alpha,
    input  logic                 in_paletted,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 pal_wen,
    input  logic [W_PAL_IDX-1:0] pal_waddr,
    input  logic [W_COLOUR-1:0]  pal_wdata,
    output logic [W_COLOUR-1:0]  out_data,
    output logic                 out_alpha,
    output logic                 out_vld,
    input  logic                 out_rdy
);

    localparam int DEPTH = 1 << W_PAL_IDX;

    logic [W_COLOUR-1:0] pal_mem [DEPTH];
    logic [W_COLOUR-1:0] ram_rdata_q;

    logic                s1_vld_q, s1_vld_d;
    logic                s1_alpha_q, s1_alpha_d;
    logic                s1_pal_q, s1_pal_d;
    logic [W_COLOUR-1:0] s1_data_q, s1_data_d;

    logic [1:0]          count_q, count_d;
    logic [W_COLOUR-1:0] head_col_q, head_col_d, tail_col_q, tail_col_d;
    logic                head_alpha_q, head_alpha_d, tail_alpha_q, tail_alpha_d;

    logic                accept_s, rd_en_s, fifo_room_s, s1_adv_s, pop_s;
    logic [W_COLOUR-1:0] s1_colour_s;
    logic                unused_s;

    // Bit 15 of a direct pixel is never a colour bit.
    assign unused_s    = ^in_data[W_PIX-1:W_COLOUR];

    // Handshake terms are built from registered state only, so out_rdy never reaches in_rdy.
    assign fifo_room_s = (count_q < 2'd2);
    assign in_rdy      = !s1_vld_q || fifo_room_s;
    assign accept_s    = in_vld && in_rdy;
    assign rd_en_s     = accept_s && in_paletted;
    assign s1_adv_s    = s1_vld_q && fifo_room_s;
    assign out_vld     = (count_q != 2'd0);
    assign pop_s       = out_vld && out_rdy;
    assign s1_colour_s = s1_pal_q ? ram_rdata_q : s1_data_q;
    assign out_data    = head_col_q;
    assign out_alpha   = head_alpha_q;

    // Palette RAM: read-first, and the read register only moves on a read enable.
    always_ff @(posedge clk) begin
        if (pal_wen) begin
            pal_mem[pal_waddr] <= pal_wdata;
        end
        if (rd_en_s) begin
            ram_rdata_q <= pal_mem[in_data[W_PAL_IDX-1:0]];
        end
    end

    // S1 next state: flush wins, then a new accept, then draining into the FIFO.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_alpha_d = s1_alpha_q;
        s1_pal_d   = s1_pal_q;
        s1_data_d  = s1_data_q;
        if (flush) begin
            s1_vld_d = 1'b0;
        end else if (accept_s) begin
            s1_vld_d   = 1'b1;
            s1_alpha_d = in_alpha;
            s1_pal_d   = in_paletted;
            s1_data_d  = in_data[W_COLOUR-1:0];
        end else if (s1_adv_s) begin
            s1_vld_d = 1'b0;
        end else begin
            s1_vld_d = s1_vld_q;
        end
    end

    // S1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_alpha_q <= 1'b0;
            s1_pal_q   <= 1'b0;
            s1_data_q  <= {W_COLOUR{1'b0}};
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_alpha_q <= s1_alpha_d;
            s1_pal_q   <= s1_pal_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // FIFO as a two-slot shift register so the head drives the outputs straight from flops.
    always_comb begin
        count_d      = count_q;
        head_col_d   = head_col_q;
        head_alpha_d = head_alpha_q;
        tail_col_d   = tail_col_q;
        tail_alpha_d = tail_alpha_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (s1_adv_s) begin
                        head_col_d   = s1_colour_s;
                        head_alpha_d = s1_alpha_q;
                        count_d      = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (s1_adv_s && pop_s) begin
                        head_col_d   = s1_colour_s;
                        head_alpha_d = s1_alpha_q;
                        count_d      = 2'd1;
                    end else if (s1_adv_s) begin
                        tail_col_d   = s1_colour_s;
                        tail_alpha_d = s1_alpha_q;
                        count_d      = 2'd2;
                    end else if (pop_s) begin
                        count_d = 2'd0;
                    end else begin
                        count_d = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_col_d   = tail_col_q;
                        head_alpha_d = tail_alpha_q;
                        count_d      = 2'd1;
                    end else begin
                        count_d = 2'd2;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            head_col_q   <= {W_COLOUR{1'b0}};
            head_alpha_q <= 1'b0;
            tail_col_q   <= {W_COLOUR{1'b0}};
            tail_alpha_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            head_col_q   <= head_col_d;
            head_alpha_q <= head_alpha_d;
            tail_col_q   <= tail_col_d;
            tail_alpha_q <= tail_alpha_d;
        end
    end

endmodule

// File: tb/tb_riscboy_ppu_palette_lookup.sv
// Bench for riscboy_ppu_palette_lookup: directed scenarios plus random traffic,
// checked by a scoreboard fed from a palette-array reference model.
module tb_riscboy_ppu_palette_lookup;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [15:0] in_data;
    logic        in_alpha;
    logic        in_paletted;
    logic        in_vld;
    logic        in_rdy;
    logic        pal_wen;
    logic [7:0]  pal_waddr;
    logic [14:0] pal_wdata;
    logic [14:0] out_data;
    logic        out_alpha;
    logic        out_vld;
    logic        out_rdy;

    typedef struct packed {
        logic [14:0] c;
        logic        a;
    } exp_t;

    exp_t        exp_q[$];
    logic [14:0] model_pal [256];
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          stalls = 0;

    riscboy_ppu_palette_lookup dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_alpha(in_alpha), .in_paletted(in_paletted),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .pal_wen(pal_wen), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .out_data(out_data), .out_alpha(out_alpha), .out_vld(out_vld), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and hold it until the handshake completes (bounded wait).
    task automatic send(input logic p, input logic [15:0] d, input logic a);
        int   waited;
        logic acc;
        logic done;
        waited = 0;
        done = 1'b0;
        in_vld = 1'b1; in_paletted = p; in_data = d; in_alpha = a;
        while (!done) begin
            @(negedge clk);
            acc = in_rdy;
            step();
            if (acc) begin
                done = 1'b1;
            end else begin
                waited++;
                stalls++;
                if (waited > 50) begin
                    total++; bad++;
                    $display("FAIL send_timeout: in_rdy stuck at 0 for %0d cycles", waited);
                    done = 1'b1;
                end
            end
        end
    endtask

    // Scoreboard: expected beats are queued at accept, compared whenever the DUT shows a beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_vld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got %h/%b expected no beat", out_data, out_alpha);
                end else begin
                    if (out_data !== exp_q[0].c || out_alpha !== exp_q[0].a) begin
                        bad++;
                        $display("FAIL beat: got %h/%b expected %h/%b at %0t",
                                 out_data, out_alpha, exp_q[0].c, exp_q[0].a, $time);
                    end
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_vld && in_rdy) begin
                exp_q.push_back({in_paletted ? model_pal[in_data[7:0]] : in_data[14:0], in_alpha});
            end
            if (pal_wen) begin
                model_pal[pal_waddr] = pal_wdata;
            end
        end
    end

    initial begin
        int pops0;
        rst_n = 1'b0; flush = 1'b0; in_data = 16'h0000; in_alpha = 1'b0; in_paletted = 1'b0;
        in_vld = 1'b0; pal_wen = 1'b0; pal_waddr = 8'h00; pal_wdata = 15'h0000; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and idle behaviour
        check("rst_out_vld", {15'd0, out_vld}, 16'd0);
        check("rst_in_rdy", {15'd0, in_rdy}, 16'd1);
        repeat (10) begin
            step();
            check("idle_out_vld", {15'd0, out_vld}, 16'd0);
        end

        // Give every palette entry a known value
        for (int i = 0; i < 256; i++) begin
            pal_wen = 1'b1; pal_waddr = 8'(i); pal_wdata = 15'($urandom);
            step();
        end
        pal_wen = 1'b0;

        // Paletted lookup latency; upper index bits ignored
        pal_wen = 1'b1; pal_waddr = 8'h12; pal_wdata = 15'h7C00;
        step();
        pal_wen = 1'b0; out_rdy = 1'b1;
        check("t2_in_rdy", {15'd0, in_rdy}, 16'd1);
        send(1'b1, 16'hAB12, 1'b1);
        in_vld = 1'b0;
        check("t2_n1_out_vld", {15'd0, out_vld}, 16'd0);
        step();
        check("t2_n2_out_vld", {15'd0, out_vld}, 16'd1);
        check("t2_out_data", {1'b0, out_data}, 16'h7C00);
        check("t2_out_alpha", {15'd0, out_alpha}, 16'd1);
        step();

        // Back-to-back direct pixels at full rate
        stalls = 0;
        for (int i = 1; i <= 8; i++) begin
            send(1'b0, {1'($urandom), 15'(i)}, 1'(i));
        end
        in_vld = 1'b0;
        check("t3_no_stall", 16'(stalls), 16'd0);
        repeat (4) step();
        check("t3_drained", 16'(exp_q.size()), 16'd0);

        // Backpressure: three absorbed, then in_rdy low, then ordered release
        out_rdy = 1'b0; stalls = 0; pops0 = pops;
        send(1'b0, 16'h0A0A, 1'b1);
        send(1'b0, 16'h0B0B, 1'b0);
        send(1'b0, 16'h0C0C, 1'b1);
        check("t4_absorb3", 16'(stalls), 16'd0);
        check("t4_in_rdy_low", {15'd0, in_rdy}, 16'd0);
        in_vld = 1'b1; in_paletted = 1'b0; in_data = 16'h0D0D; in_alpha = 1'b0;
        repeat (3) step();
        check("t4_still_blocked", {15'd0, in_rdy}, 16'd0);
        check("t4_hold_head", {1'b0, out_data}, 16'h0A0A);
        out_rdy = 1'b1;
        send(1'b0, 16'h0D0D, 1'b0);
        in_vld = 1'b0;
        repeat (6) step();
        check("t4_four_out", 16'(pops - pops0), 16'd4);
        check("t4_drained", 16'(exp_q.size()), 16'd0);

        // Read-first: write in the accept cycle does not affect that pixel
        pal_wen = 1'b1; pal_waddr = 8'h05; pal_wdata = 15'h001F;
        step();
        pal_wdata = 15'h03E0;
        send(1'b1, 16'h0005, 1'b1);
        pal_wen = 1'b0;
        send(1'b1, 16'h0005, 1'b0);
        in_vld = 1'b0;
        check("t5_old_data", {1'b0, out_data}, 16'h001F);
        step();
        check("t5_new_data", {1'b0, out_data}, 16'h03E0);
        repeat (3) step();

        // Flush with three pixels in flight
        out_rdy = 1'b0;
        send(1'b0, 16'h0111, 1'b1);
        send(1'b0, 16'h0222, 1'b1);
        send(1'b0, 16'h0333, 1'b1);
        in_vld = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_out_vld", {15'd0, out_vld}, 16'd0);
        check("t6_in_rdy", {15'd0, in_rdy}, 16'd1);
        send(1'b0, 16'h9234, 1'b1);
        in_vld = 1'b0;
        check("t6_n1_out_vld", {15'd0, out_vld}, 16'd0);
        step();
        check("t6_n2_out_vld", {15'd0, out_vld}, 16'd1);
        check("t6_out_data", {1'b0, out_data}, 16'h1234);
        out_rdy = 1'b1;
        repeat (3) step();

        // Async reset mid-stream clears valids, palette survives
        out_rdy = 1'b0;
        send(1'b0, 16'h0044, 1'b1);
        send(1'b0, 16'h0055, 1'b1);
        in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_vld", {15'd0, out_vld}, 16'd0);
        check("rst_mid_in_rdy", {15'd0, in_rdy}, 16'd1);
        step();
        rst_n = 1'b1; out_rdy = 1'b1;
        send(1'b1, 16'h0012, 1'b0);
        in_vld = 1'b0;
        step();
        check("rst_pal_kept", {1'b0, out_data}, 16'h7C00);
        repeat (2) step();

        // Random traffic, including flush and concurrent palette writes
        for (int i = 0; i < 3000; i++) begin
            in_vld      = ($urandom % 4) != 0;
            in_paletted = 1'($urandom);
            in_data     = 16'($urandom);
            in_alpha    = 1'($urandom);
            pal_wen     = ($urandom % 3) == 0;
            pal_waddr   = 8'($urandom);
            pal_wdata   = 15'($urandom);
            out_rdy     = ($urandom % 4) != 0;
            flush       = ($urandom % 64) == 0;
            step();
        end
        in_vld = 1'b0; pal_wen = 1'b0; flush = 1'b0; out_rdy = 1'b1;
        repeat (6) step();
        check("rand_drained", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
